// File: rtl/data_memory.sv
// rtl/data_memory.sv - CPU data memory with host preload/dump port, access counters and error flag
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   CEN, WEN, OEN, A           CPU strobes (active low) and word address
//   Data2Mem, ReadDataMem      CPU write data in, zero-latency read data out
//   host_valid/host_ready      host request handshake (CPU has priority)
//   host_we, host_addr,
//   host_wdata                 host request fields
//   host_rdata, host_rvalid    registered host read response, one-cycle pulse
//   rd_cnt, wr_cnt             saturating CPU read/write counters
//   err_rw                     sticky flag for simultaneous CPU WEN/OEN low
module data_memory #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic              err_rw
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } host_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  host_state_e       state_q, state_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              err_rw_q, err_rw_d;

  logic cpu_wr;
  logic cpu_rd;
  logic cpu_oe;
  logic host_fire;

  // A write wins over a read when both strobes are low; the read port
  // still shows the pre-write contents in that case.
  assign cpu_wr    = ~CEN & ~WEN;
  assign cpu_rd    = ~CEN & ~OEN & WEN;
  assign cpu_oe    = ~CEN & ~OEN;

  // Host is only served while the CPU is deselected, so host and CPU
  // writes can never target the array on the same edge.
  assign host_ready = (state_q == IDLE) & CEN;
  assign host_fire  = host_valid & host_ready;

  assign ReadDataMem = cpu_oe ? mem_q[A] : '0;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;
  assign err_rw      = err_rw_q;

  always_comb begin
    mem_d         = mem_q;
    state_d       = state_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    err_rw_d      = err_rw_q;

    if (cpu_wr) begin
      mem_d[A] = Data2Mem;
    end else if (host_fire && host_we) begin
      mem_d[host_addr] = host_wdata;
    end

    case (state_q)
      IDLE: begin
        if (host_fire && !host_we) begin
          host_rdata_d  = mem_q[host_addr];
          host_rvalid_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cpu_rd && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (cpu_wr && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (cpu_wr && !OEN) begin
      err_rw_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q       <= IDLE;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      err_rw_q      <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      state_q       <= state_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      err_rw_q      <= err_rw_d;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory with a behavioural model
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        host_valid, host_ready, host_we;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_rvalid;
  logic [15:0] rd_cnt, wr_cnt;
  logic        err_rw;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_mem [128];
  int          m_rd, m_wr;
  logic        m_err;
  logic        m_resp;
  logic [31:0] m_hrdata;

  data_memory #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_rw(err_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
    m_rd = 0; m_wr = 0; m_err = 1'b0; m_resp = 1'b0; m_hrdata = 32'h0;
  endtask

  // One clock of stimulus: drive, check combinational outputs, advance, check state.
  task automatic cycle(input logic cen, input logic wen, input logic oen,
                       input logic [6:0] a, input logic [31:0] d,
                       input logic hv, input logic hwe,
                       input logic [6:0] ha, input logic [31:0] hwd);
    logic        exp_ready;
    logic [31:0] exp_rdm;
    CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
    host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
    #1;
    exp_ready = !m_resp && cen;
    exp_rdm   = (!cen && !oen) ? m_mem[a] : 32'h0;
    check("host_ready", {31'h0, host_ready}, {31'h0, exp_ready});
    check("ReadDataMem", ReadDataMem, exp_rdm);
    // Model the edge using pre-edge values
    m_resp = 1'b0;
    if (!cen && !oen && wen && m_rd < 65535) m_rd++;
    if (!cen && !wen) begin
      m_mem[a] = d;
      if (m_wr < 65535) m_wr++;
      if (!oen) m_err = 1'b1;
    end
    if (hv && exp_ready) begin
      if (hwe) m_mem[ha] = hwd;
      else begin
        m_hrdata = m_mem[ha];
        m_resp   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("host_rvalid", {31'h0, host_rvalid}, {31'h0, m_resp});
    check("host_rdata", host_rdata, m_hrdata);
    check("rd_cnt", {16'h0, rd_cnt}, m_rd[31:0]);
    check("wr_cnt", {16'h0, wr_cnt}, m_wr[31:0]);
    check("err_rw", {31'h0, err_rw}, {31'h0, m_err});
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
  endtask

  initial begin
    logic        hv_p, hwe_p;
    logic [6:0]  ha_p;
    logic [31:0] hwd_p;
    logic        cen_r, wen_r, oen_r;

    rst_n = 1'b0;
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    model_reset();

    // Reset state
    #3;
    check("rst_host_rvalid", {31'h0, host_rvalid}, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
    check("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    check("rst_err_rw", {31'h0, err_rw}, 32'h0);
    check("rst_host_ready", {31'h0, host_ready}, 32'h1);
    #9 rst_n = 1'b1;

    // CPU write then zero-latency read
    cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 1'b0, 7'd0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    check("rd_after_wr_ReadDataMem_hold", ReadDataMem, 32'hDEADBEEF);
    check("wr_cnt_is_1", {16'h0, wr_cnt}, 32'd1);
    check("rd_cnt_is_1", {16'h0, rd_cnt}, 32'd1);

    // Host write then read at the top address
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b1, 1'b1, 7'd127, 32'h12345678);
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b1, 1'b0, 7'd127, 32'h0);
    check("host_rd127_data", host_rdata, 32'h12345678);
    check("host_rd127_valid", {31'h0, host_rvalid}, 32'h1);
    idle();
    check("host_rvalid_drops", {31'h0, host_rvalid}, 32'h0);
    check("host_rdata_holds", host_rdata, 32'h12345678);

    // Host waits while the CPU holds CEN low
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b1, 7'd1, 32'h0, 1'b1, 1'b1, 7'd20, 32'hA5A5_0020);
    cycle(1'b1, 1'b1, 1'b1, 7'd1, 32'h0, 1'b1, 1'b1, 7'd20, 32'hA5A5_0020);
    cycle(1'b0, 1'b1, 1'b0, 7'd20, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);

    // Simultaneous WEN/OEN: write happens, old data read, sticky error
    cycle(1'b0, 1'b0, 1'b0, 7'd3, 32'h1, 1'b0, 1'b0, 7'd0, 32'h0);
    check("err_rw_set", {31'h0, err_rw}, 32'h1);
    idle();
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    check("err_rw_sticky", {31'h0, err_rw}, 32'h1);

    // Write counter saturation
    force dut.wr_cnt_q = 16'hFFFE;
    #1;
    release dut.wr_cnt_q;
    m_wr = 32'hFFFE;
    #1;
    check("wr_cnt_preset", {16'h0, wr_cnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 7'(40 + i), 32'h100 + i, 1'b0, 1'b0, 7'd0, 32'h0);
    check("wr_cnt_saturated", {16'h0, wr_cnt}, 32'hFFFF);

    // Randomized traffic; host request fields held until accepted
    hv_p = 1'b0; hwe_p = 1'b0; ha_p = '0; hwd_p = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hv_p && ($urandom_range(0, 2) != 0)) begin
        hv_p  = 1'b1;
        hwe_p = $urandom_range(0, 1);
        ha_p  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
        hwd_p = $urandom;
      end
      cen_r = ($urandom_range(0, 1) == 0);
      wen_r = ($urandom_range(0, 2) != 0);
      oen_r = ($urandom_range(0, 3) == 0);
      if (hv_p && !m_resp && cen_r) begin
        cycle(cen_r, wen_r, oen_r, 7'($urandom_range(0, 15)), $urandom, hv_p, hwe_p, ha_p, hwd_p);
        hv_p = 1'b0;
      end else begin
        cycle(cen_r, wen_r, oen_r, 7'($urandom_range(0, 15)), $urandom, hv_p, hwe_p, ha_p, hwd_p);
      end
    end
    idle();
    idle();

    // Reset asserted mid-cycle during a host response
    cycle(1'b0, 1'b0, 1'b1, 7'd9, 32'd7, 1'b0, 1'b0, 7'd0, 32'h0);
    idle();
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b1, 1'b0, 7'd9, 32'h0);
    check("resp_before_reset", {31'h0, host_rvalid}, 32'h1);
    check("rdata_before_reset", host_rdata, 32'd7);
    host_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_host_rvalid", {31'h0, host_rvalid}, 32'h0);
    check("midrst_host_rdata", host_rdata, 32'h0);
    check("midrst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
    check("midrst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    check("midrst_err_rw", {31'h0, err_rw}, 32'h0);
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'd9;
    #1;
    check("inrst_read9", ReadDataMem, 32'h0);
    rst_n = 1'b1;
    #1;
    cycle(1'b0, 1'b1, 1'b0, 7'd9, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
